processing_unit_param: RTL
==========================

Name: processing_unit_param

Overview:
Parametrised next-generation RISC datapath: register file, program counter, instruction register, operand register Y, 4-bit status-flag register, address register, ALU and the two bus multiplexers.
- The controller drives every control input. This block returns the instruction word, memory address, Bus_1 and status flags.
- Adds over the previous datapath: explicit register-file write enable, signed PC-relative offsets, a full NZCV flag register, a global stall, and an optional hardwired-zero R0.
- Sits between the control unit and the instruction/data memory.

Parameters:
- DATA_WIDTH, 16, width of registers, buses and ALU (>=12).
- ADDR_WIDTH, 8, width of PC, Reg_A and memory address (<=DATA_WIDTH).
- NUM_REGS, 16, register-file depth (power of two, >=4).
- RF_ADDR_WIDTH, $clog2(NUM_REGS), register-file address width.
- SEL1_WIDTH, $clog2(NUM_REGS+2), Bus_1 select width.
- R0_ZERO, 0, when 1 R0 reads as 0 and writes to it are discarded.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  freezes all state when high.
- mem_read_data  in  DATA_WIDTH  data from memory.
- RF_W_Addr  in  RF_ADDR_WIDTH  register-file write address.
- RF_We  in  1  register-file write enable.
- PC_Ld  in  1  load PC.
- PC_Inc  in  1  increment PC.
- sel_PC_Offset_Update  in  1  PC load source: 0 = offset target, 1 = Bus_2.
- Sel_Bus_1_MUX  in  SEL1_WIDTH  Bus_1 source select.
- Sign_Ext_Flag  in  1  immediate is sign-extended (1) or zero-extended (0).
- IR_Ld  in  1  load IR from Bus_2.
- Reg_Y_Ld  in  1  load Reg_Y from Bus_2.
- Sel_Bus_2_MUX  in  2  Bus_2 source select.
- Reg_A_Ld  in  1  load Reg_A from Bus_2.
- Flags_Ld  in  1  load the flag register from the ALU.
- instruction  out  DATA_WIDTH  IR contents.
- address  out  ADDR_WIDTH  Reg_A contents.
- Bus_1  out  DATA_WIDTH  Bus_1 value.
- RF_Ry_Zero  out  1  Reg_Y == 0 (combinational).
- alu_zero  out  1  flag Z.
- alu_neg  out  1  flag N.
- alu_carry  out  1  flag C.
- alu_ovf  out  1  flag V.

Behaviour:
Reset and stall
- Synchronous reset: RF, PC, IR, Reg_Y, Reg_A and flags all go to 0. Reset overrides stall and all load signals.
- When stall=1 and rst=0, no register changes. Combinational outputs still follow the current selects.

Bus_1 select
- 0..NUM_REGS-1 selects R[sel].
- NUM_REGS selects PC, zero-extended.
- NUM_REGS+1 selects the immediate built from IR[7:0], sign- or zero-extended per Sign_Ext_Flag.
- Any other value gives 0.

Bus_2 select
- 0 = ALU out, 1 = Bus_1, 2 = mem_read_data, 3 = 0.

Register file
- Writes Bus_2 into R[RF_W_Addr] only when RF_We=1.
- With R0_ZERO=1, a write to R0 is dropped and R0 reads 0.

PC
- Priority: PC_Ld over PC_Inc. Increment is +1 modulo 2^ADDR_WIDTH; 0xFF+1 wraps to 0x00.
- Load source 1 takes Bus_2[ADDR_WIDTH-1:0].
- Load source 0 takes PC + sext(IR[7:0]) - 1, modulo 2^ADDR_WIDTH.

Other registers
- IR, Reg_Y and Reg_A each load Bus_2 on their load signal; Reg_A takes Bus_2[ADDR_WIDTH-1:0].

ALU
- Inputs: A = Reg_Y, B = Bus_1. Opcode = IR[DATA_WIDTH-1:DATA_WIDTH-4].
- Opcodes:
  - 0 → 0
  - 1 → A+B
  - 2 → A-B
  - 3 → A&B
  - 4 → A|B
  - 5 → A^B
  - 6 → ~B
  - 7 → A<<1
  - 8 → A>>1 (logical)
  - 9–15 → B
- Flags are computed combinationally and registered on Flags_Ld.
- Z = (out==0). N = out MSB.
- C: carry-out for ADD; borrow (A<B unsigned) for SUB; shifted-out bit for shifts; 0 otherwise.
- V: signed overflow for ADD/SUB; 0 otherwise.

Latency and simultaneous events
- Every register update takes 1 cycle. Values written are visible on Bus_1 in the next cycle.
- Same-edge RF write and Bus_1 read of the same register: Bus_1 shows the old value that cycle.

Test Plan:
- Reset and write enable: rst=1 for 2 cycles, then RF_We=1, RF_W_Addr=3, Sel_Bus_2=1, Bus_1=imm 0x7F → R3=0x007F next cycle. Repeat with RF_We=0 → R3 unchanged. With R0_ZERO=1, a write of 0x1234 to R0 → R0 reads 0.
- ADD overflow: Reg_Y=0x7FFF, R1=0x0001, IR opcode 1, Flags_Ld → ALU out 0x8000, N=1, V=1, C=0, Z=0. Opcode 2 with Reg_Y=R1=0x0005 → Z=1, C=0.
- Signed PC offset: PC=0x10, IR[7:0]=0xFE, PC_Ld=1, sel_PC_Offset_Update=0 → PC=0x0D. PC=0xFF with PC_Inc → 0x00. PC_Ld and PC_Inc together → load wins.
- Stall: stall=1 with every load high and RF_We=1 for 3 cycles → no state changes. Deassert stall → loads take effect on the next edge.
- Memory path: Sel_Bus_2=2, mem_read_data=0xA5C3, IR_Ld=1 → instruction=0xA5C3. Reg_A_Ld with same Bus_2 → address=0xC3.
- Immediate extension: IR[7:0]=0x80, Sign_Ext_Flag=1 → Bus_1=0xFF80; Sign_Ext_Flag=0 → 0x0080. Out-of-range Sel_Bus_1 → Bus_1=0.

Source files
------------

// File: rtl/processing_unit_param.sv
// processing_unit_param
// Parametrised RISC datapath: register file, program counter, instruction
// register, operand register Y, NZCV flag register, address register, ALU and
// the Bus_1 / Bus_2 source multiplexers. Every control input comes from an
// external controller.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   stall                 holds every register when high
//   mem_read_data         memory data, a Bus_2 source
//   RF_W_Addr, RF_We      register-file write port (data = Bus_2)
//   PC_Ld, PC_Inc         PC load (wins) / increment
//   sel_PC_Offset_Update  PC load source: 0 = PC + sext(IR[7:0]) - 1, 1 = Bus_2
//   Sel_Bus_1_MUX         Bus_1 source: R[n], PC, IR immediate, else 0
//   Sign_Ext_Flag         immediate sign- (1) or zero- (0) extension
//   IR_Ld, Reg_Y_Ld,
//   Reg_A_Ld, Flags_Ld    register load enables
//   Sel_Bus_2_MUX         Bus_2 source: ALU, Bus_1, memory, 0
//   instruction, address  IR and Reg_A contents
//   Bus_1                 current Bus_1 value
//   RF_Ry_Zero            Reg_Y == 0
//   alu_zero/neg/carry/ovf registered Z/N/C/V flags
module processing_unit_param #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 8,
  parameter int NUM_REGS      = 16,
  parameter int RF_ADDR_WIDTH = $clog2(NUM_REGS),
  parameter int SEL1_WIDTH    = $clog2(NUM_REGS + 2),
  parameter bit R0_ZERO       = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic [DATA_WIDTH-1:0]    mem_read_data,
  input  logic [RF_ADDR_WIDTH-1:0] RF_W_Addr,
  input  logic                     RF_We,
  input  logic                     PC_Ld,
  input  logic                     PC_Inc,
  input  logic                     sel_PC_Offset_Update,
  input  logic [SEL1_WIDTH-1:0]    Sel_Bus_1_MUX,
  input  logic                     Sign_Ext_Flag,
  input  logic                     IR_Ld,
  input  logic                     Reg_Y_Ld,
  input  logic [1:0]               Sel_Bus_2_MUX,
  input  logic                     Reg_A_Ld,
  input  logic                     Flags_Ld,
  output logic [DATA_WIDTH-1:0]    instruction,
  output logic [ADDR_WIDTH-1:0]    address,
  output logic [DATA_WIDTH-1:0]    Bus_1,
  output logic                     RF_Ry_Zero,
  output logic                     alu_zero,
  output logic                     alu_neg,
  output logic                     alu_carry,
  output logic                     alu_ovf
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = ADDR_WIDTH;

  typedef enum logic [3:0] {
    OP_ZERO = 4'd0, OP_ADD = 4'd1, OP_SUB = 4'd2, OP_AND = 4'd3, OP_OR = 4'd4,
    OP_XOR  = 4'd5, OP_NOT = 4'd6, OP_SHL = 4'd7, OP_SHR = 4'd8
  } alu_op_e;

  // State
  logic [DW-1:0] rf_q [NUM_REGS];
  logic [DW-1:0] rf_d [NUM_REGS];
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [DW-1:0] reg_y_q, reg_y_d;
  logic [AW-1:0] reg_a_q, reg_a_d;
  logic [3:0]    flags_q, flags_d;   // {N, Z, C, V}

  // Datapath nets
  logic [DW-1:0] imm;
  logic [AW-1:0] pc_ofs;
  logic [DW-1:0] bus_1, bus_2;
  logic [3:0]    opcode;
  logic [DW-1:0] alu_out;
  logic [DW:0]   add_wide;
  logic          alu_c, alu_v;

  // Immediate for Bus_1 follows Sign_Ext_Flag; the branch offset is always signed.
  assign imm    = {{(DW-8){Sign_Ext_Flag & ir_q[7]}}, ir_q[7:0]};
  assign pc_ofs = AW'($signed(ir_q[7:0]));
  assign opcode = ir_q[DW-1:DW-4];

  // NOTE: combinational blocks assign every output a default first, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    bus_1 = '0;
    if (Sel_Bus_1_MUX < SEL1_WIDTH'(NUM_REGS)) begin
      if (!(R0_ZERO && Sel_Bus_1_MUX == '0)) begin
        bus_1 = rf_q[Sel_Bus_1_MUX[RF_ADDR_WIDTH-1:0]];
      end
    end else if (Sel_Bus_1_MUX == SEL1_WIDTH'(NUM_REGS)) begin
      bus_1 = DW'(pc_q);
    end else if (Sel_Bus_1_MUX == SEL1_WIDTH'(NUM_REGS + 1)) begin
      bus_1 = imm;
    end
  end

  // ALU: A = Reg_Y, B = Bus_1.
  always_comb begin
    alu_out  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    add_wide = '0;
    case (opcode)
      OP_ZERO: alu_out = '0;
      OP_ADD: begin
        add_wide = {1'b0, reg_y_q} + {1'b0, bus_1};
        alu_out  = add_wide[DW-1:0];
        alu_c    = add_wide[DW];
        // Overflow: like-signed operands producing a result of the other sign.
        alu_v    = (reg_y_q[DW-1] == bus_1[DW-1]) && (alu_out[DW-1] != reg_y_q[DW-1]);
      end
      OP_SUB: begin
        alu_out = reg_y_q - bus_1;
        alu_c   = reg_y_q < bus_1;   // borrow
        alu_v   = (reg_y_q[DW-1] != bus_1[DW-1]) && (alu_out[DW-1] != reg_y_q[DW-1]);
      end
      OP_AND: alu_out = reg_y_q & bus_1;
      OP_OR:  alu_out = reg_y_q | bus_1;
      OP_XOR: alu_out = reg_y_q ^ bus_1;
      OP_NOT: alu_out = ~bus_1;
      OP_SHL: begin
        alu_out = {reg_y_q[DW-2:0], 1'b0};
        alu_c   = reg_y_q[DW-1];
      end
      OP_SHR: begin
        alu_out = {1'b0, reg_y_q[DW-1:1]};
        alu_c   = reg_y_q[0];
      end
      default: alu_out = bus_1;
    endcase
  end

  always_comb begin
    case (Sel_Bus_2_MUX)
      2'd0:    bus_2 = alu_out;
      2'd1:    bus_2 = bus_1;
      2'd2:    bus_2 = mem_read_data;
      default: bus_2 = '0;
    endcase
  end

  // Next state: hold by default; stall blocks every update.
  always_comb begin
    rf_d    = rf_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    reg_y_d = reg_y_q;
    reg_a_d = reg_a_q;
    flags_d = flags_q;
    if (!stall) begin
      if (RF_We && !(R0_ZERO && RF_W_Addr == '0)) rf_d[RF_W_Addr] = bus_2;
      if (PC_Ld) begin
        pc_d = sel_PC_Offset_Update ? bus_2[AW-1:0] : pc_q + pc_ofs - AW'(1);
      end else if (PC_Inc) begin
        pc_d = pc_q + AW'(1);
      end
      if (IR_Ld)    ir_d    = bus_2;
      if (Reg_Y_Ld) reg_y_d = bus_2;
      if (Reg_A_Ld) reg_a_d = bus_2[AW-1:0];
      if (Flags_Ld) flags_d = {alu_out[DW-1], alu_out == '0, alu_c, alu_v};
    end
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples pre-edge values and a same-edge RF write is unseen on Bus_1 until
  // the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the register file is built from flops and must read 0 after
      // reset, so it is cleared here along with the other registers.
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
      pc_q    <= '0;
      ir_q    <= '0;
      reg_y_q <= '0;
      reg_a_q <= '0;
      flags_q <= '0;
    end else begin
      rf_q    <= rf_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      reg_y_q <= reg_y_d;
      reg_a_q <= reg_a_d;
      flags_q <= flags_d;
    end
  end

  assign instruction = ir_q;
  assign address     = reg_a_q;
  assign Bus_1       = bus_1;
  assign RF_Ry_Zero  = (reg_y_q == '0);
  assign alu_neg     = flags_q[3];
  assign alu_zero    = flags_q[2];
  assign alu_carry   = flags_q[1];
  assign alu_ovf     = flags_q[0];

endmodule
